// File: rtl/morse_seq_tx_if.sv
// Request/status bundle between the character-to-pattern encoder and the Morse element sequencer.
// The encoder drives the master side. The sequencer uses the slave side.
interface morse_seq_tx_if #(
    parameter int MAX_BITS = 16,
    parameter int LEN_W    = 5
);
    logic                start;
    logic [MAX_BITS-1:0] pattern;
    logic [LEN_W-1:0]    length;
    logic                repeat_en;   // "repeat" is a reserved word, hence the suffix
    logic                abort;
    logic                light;
    logic                busy;
    logic                done;
    logic [LEN_W-1:0]    bit_idx;

    modport master (
        output start, pattern, length, repeat_en, abort,
        input  light, busy, done, bit_idx
    );

    modport slave (
        input  start, pattern, length, repeat_en, abort,
        output light, busy, done, bit_idx
    );
endinterface

// File: rtl/morse_seq_tx.sv
// Morse element sequencer: shows a latched on/off pattern LSB first, one element per tick,
// then appends an inter-character gap and optionally repeats the character.
module morse_seq_tx #(
    parameter int MAX_BITS  = 16,
    parameter int LEN_W     = 5,
    parameter int GAP_TICKS = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    morse_seq_tx_if.slave bus
);
    localparam int                GAP_W    = $clog2(GAP_TICKS + 2);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_TICKS);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] pat_q, pat_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic [MAX_BITS-1:0] shreg_next;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_clamped;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                light_q, light_d;
    logic                busy_q, done_q;
    logic                pass_end;

    assign len_clamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    assign shreg_next  = shreg_q >> 1;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        light_d  = light_q;
        idx_d    = idx_q;
        pass_end = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            light_d = 1'b0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            pat_d   = bus.pattern;
                            len_d   = len_clamped;
                            shreg_d = bus.pattern;
                            cnt_d   = len_clamped;
                            state_d = ARM;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                ARM: begin
                    if (tick) begin
                        state_d = SHIFT;
                        light_d = shreg_q[0];
                        idx_d   = '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (cnt_q == LEN_ONE) begin
                            if (GAP_TICKS > 0) begin
                                state_d = GAP;
                                gap_d   = GAP_LOAD;
                                light_d = 1'b0;
                                idx_d   = '0;
                            end else begin
                                pass_end = 1'b1;
                            end
                        end else begin
                            shreg_d = shreg_next;
                            cnt_d   = cnt_q - LEN_ONE;
                            idx_d   = idx_q + LEN_ONE;
                            light_d = shreg_next[0];
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_q == GAP_ONE) begin
                            pass_end = 1'b1;
                        end else begin
                            gap_d = gap_q - GAP_ONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // End of pass resolves in the same edge: restart from the latched copy or finish.
            if (pass_end) begin
                idx_d = '0;
                if (bus.repeat_en) begin
                    shreg_d = pat_q;
                    cnt_d   = len_q;
                    light_d = pat_q[0];
                    state_d = SHIFT;
                end else begin
                    light_d = 1'b0;
                    state_d = DONE;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            light_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            light_q <= light_d;
            idx_q   <= idx_d;
            // busy and done trail the state by one edge; abort clears them at once
            busy_q  <= !bus.abort && (state_q inside {ARM, SHIFT, GAP});
            done_q  <= !bus.abort && (state_q == DONE);
        end
    end

    assign bus.light   = light_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_idx = idx_q;
endmodule
